// File: rtl/mmio_xbar.sv
// Registered MMIO crossbar: base/mask decode, request handshake,
// device timeout and bus-error reporting.
module mmio_xbar #(
  parameter int                   N_DEVS    = 8,
  parameter logic [N_DEVS*32-1:0] DEV_BASE  = {N_DEVS{32'h0}},
  parameter logic [N_DEVS*32-1:0] DEV_MASK  = {N_DEVS{32'hFFFFFFFF}},
  parameter int                   TIMEOUT   = 255,
  parameter logic [31:0]          ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   mmio_read,
  input  logic                   mmio_write,
  input  logic [31:0]            mmio_addr,
  input  logic [31:0]            mmio_write_data,
  output logic                   mmio_done,
  output logic [31:0]            mmio_read_data,
  output logic                   mmio_error,
  output logic [31:0]            err_addr,
  output logic [N_DEVS-1:0]      dev_sel,
  output logic                   dev_read,
  output logic                   dev_write,
  output logic [31:0]            dev_addr,
  output logic [31:0]            dev_wdata,
  input  logic [N_DEVS-1:0]      dev_done,
  input  logic [N_DEVS*32-1:0]   dev_rdata
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, RESP, RELEASE
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t state, state_d;
  logic [15:0] cnt;
  logic [N_DEVS-1:0] hit_oh;
  logic hit_any;
  logic sel_done;
  logic [31:0] sel_rdata;
  logic req, bad_op;
  logic resp_go, resp_err;
  logic [31:0] resp_data;

  assign req    = mmio_read | mmio_write;
  assign bad_op = mmio_read & mmio_write;

  // Lowest matching channel wins.
  always_comb begin
    hit_oh  = '0;
    hit_any = 1'b0;
    for (int i = 0; i < N_DEVS; i++) begin
      if (!hit_any &&
          ((mmio_addr & DEV_MASK[32*i +: 32]) ==
           (DEV_BASE[32*i +: 32] & DEV_MASK[32*i +: 32]))) begin
        hit_oh[i] = 1'b1;
        hit_any   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_done  = |(dev_done & dev_sel);
    sel_rdata = '0;
    for (int i = 0; i < N_DEVS; i++) begin
      if (dev_sel[i]) sel_rdata = sel_rdata | dev_rdata[32*i +: 32];
    end
  end

  always_comb begin
    state_d   = state;
    resp_go   = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (bad_op || !hit_any) begin
            state_d  = RESP;
            resp_go  = 1'b1;
            resp_err = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (sel_done) begin
          state_d   = RESP;
          resp_go   = 1'b1;
          resp_data = dev_read ? sel_rdata : 32'h0;
        end else if (cnt == TO_LAST) begin
          state_d  = RESP;
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end
      end
      RESP:    state_d = RELEASE;
      RELEASE: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      mmio_done      <= 1'b0;
      mmio_read_data <= '0;
      mmio_error     <= 1'b0;
      err_addr       <= '0;
      dev_sel        <= '0;
      dev_read       <= 1'b0;
      dev_write      <= 1'b0;
      dev_addr       <= '0;
      dev_wdata      <= '0;
    end else begin
      state          <= state_d;
      mmio_done      <= resp_go;
      mmio_error     <= resp_go & resp_err;
      mmio_read_data <= !resp_go ? 32'h0 :
                        resp_err ? ERR_RDATA : resp_data;
      if (state == ACCESS && !resp_go) cnt <= cnt + 16'd1;
      else cnt <= '0;
      if (state == IDLE && req) begin
        dev_addr  <= mmio_addr;
        dev_wdata <= mmio_write_data;
      end
      if (state == IDLE && state_d == ACCESS) begin
        dev_sel   <= hit_oh;
        dev_read  <= mmio_read;
        dev_write <= mmio_write;
      end
      // Strobes drop together with the completion pulse.
      if (resp_go) begin
        dev_sel   <= '0;
        dev_read  <= 1'b0;
        dev_write <= 1'b0;
      end
      if (resp_go && resp_err)
        err_addr <= (state == IDLE) ? mmio_addr : dev_addr;
    end
  end

endmodule

// File: tb/tb_mmio_xbar.sv
// Bench for mmio_xbar: vector table with a scoreboard queue,
// plus held-request, overlap and mid-access reset sequences.
module tb_mmio_xbar;
  localparam int N = 8;
  localparam int TO = 4;
  localparam logic [N*32-1:0] BASE = {
    32'h30007000, 32'h30006000, 32'h20000000, 32'h30004000,
    32'h30003000, 32'h20000000, 32'hFFFF0080, 32'hFFFF0000};
  localparam logic [N*32-1:0] MASK = {
    32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000,
    32'hFFFFF000, 32'hFFFF0000, 32'hFFFFFF80, 32'hFFFFFF80};

  logic sys_clk = 0, rst_n = 0;
  logic mmio_read = 0, mmio_write = 0;
  logic [31:0] mmio_addr = 0, mmio_write_data = 0;
  logic mmio_done, mmio_error;
  logic [31:0] mmio_read_data, err_addr, dev_addr, dev_wdata;
  logic [N-1:0] dev_sel, dev_done, extra_done = 0;
  logic dev_read, dev_write;
  logic [N*32-1:0] dev_rdata;
  logic [7:0] lat_all = 8'd0;
  logic [7:0] wcnt [N];

  int checks = 0, errors = 0;
  logic [31:0] last_err = 0;

  typedef struct {
    logic rd, wr;
    logic [31:0] addr, wdata;
    logic [7:0] lat;
    logic [N-1:0] xdone;
    logic [N-1:0] sel;
    int cyc;
    logic err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  mmio_xbar #(
    .N_DEVS(N), .DEV_BASE(BASE), .DEV_MASK(MASK),
    .TIMEOUT(TO), .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .mmio_read(mmio_read), .mmio_write(mmio_write),
    .mmio_addr(mmio_addr), .mmio_write_data(mmio_write_data),
    .mmio_done(mmio_done), .mmio_read_data(mmio_read_data),
    .mmio_error(mmio_error), .err_addr(err_addr),
    .dev_sel(dev_sel), .dev_read(dev_read), .dev_write(dev_write),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_done(dev_done), .dev_rdata(dev_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] chan_data(int i);
    return (i == 1) ? 32'h12345678 : (32'hC0DE0000 | 32'(i));
  endfunction

  // Device model: channel answers lat_all cycles after being selected.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < N; i++)
      wcnt[i] <= dev_sel[i] ? wcnt[i] + 8'd1 : 8'd0;
  end

  always_comb begin
    dev_done  = extra_done;
    dev_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (dev_sel[i] && wcnt[i] == lat_all) dev_done[i] = 1'b1;
      dev_rdata[32*i +: 32] = chan_data(i);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit got;
    logic [N-1:0] seen_sel;
    logic [31:0] seen_addr;
    vec_t e;
    @(negedge sys_clk);
    mmio_read = v.rd; mmio_write = v.wr;
    mmio_addr = v.addr; mmio_write_data = v.wdata;
    lat_all = v.lat; extra_done = v.xdone;
    sb.push_back(v);
    cyc = 0; got = 0; seen_sel = '0; seen_addr = '0;
    while (!got && cyc < 20) begin
      @(posedge sys_clk); #1;
      cyc++;
      if (dev_sel != 0 && seen_sel == 0) begin
        seen_sel = dev_sel;
        seen_addr = dev_addr;
      end
      if (mmio_done) begin
        got = 1;
        e = sb.pop_front();
        if (e.err) last_err = e.addr;
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(e.cyc));
        chk($sformatf("v%0d dev_sel", idx), 32'(seen_sel), 32'(e.sel));
        chk($sformatf("v%0d error", idx), 32'(mmio_error), 32'(e.err));
        chk($sformatf("v%0d rdata", idx), mmio_read_data, e.rdata);
        chk($sformatf("v%0d err_addr", idx), err_addr, last_err);
        chk($sformatf("v%0d sel_drop", idx), 32'(dev_sel), 32'h0);
        if (e.sel != 0)
          chk($sformatf("v%0d dev_addr", idx), seen_addr, e.addr);
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL v%0d done_timeout: got no mmio_done expected one", idx);
      void'(sb.pop_front());
    end
    @(posedge sys_clk); #1;
    chk($sformatf("v%0d one_pulse", idx), 32'(mmio_done), 32'h0);
    @(negedge sys_clk);
    mmio_read = 0; mmio_write = 0; extra_done = '0;
    repeat (2) @(posedge sys_clk);
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] a,
      logic [7:0] lat, logic [N-1:0] xd, logic [N-1:0] sel, int cyc,
      logic err, logic [31:0] rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = a ^ 32'h5A5A5A5A;
    v.lat = lat; v.xdone = xd; v.sel = sel; v.cyc = cyc;
    v.err = err; v.rdata = rdata;
    return v;
  endfunction

  initial begin
    int pulses;
    vecs.push_back(mk(1,0,32'hFFFF0084,0,0,8'b0000_0010,2,0,32'h12345678));
    vecs.push_back(mk(1,0,32'h00001000,0,0,8'b0,1,1,32'hDEADBEEF));
    vecs.push_back(mk(0,1,32'hFFFF0010,255,0,8'b0000_0001,5,1,32'hDEADBEEF));
    vecs.push_back(mk(0,1,32'hFFFF0090,2,0,8'b0000_0010,4,0,32'h0));
    vecs.push_back(mk(1,0,32'h20000010,1,8'b0010_0000,8'b0000_0100,3,0,32'hC0DE0002));
    vecs.push_back(mk(1,0,32'h30003004,0,0,8'b0000_1000,2,0,32'hC0DE0003));
    vecs.push_back(mk(1,1,32'hFFFF0084,0,0,8'b0,1,1,32'hDEADBEEF));
    vecs.push_back(mk(1,0,32'h30007000,3,0,8'b1000_0000,5,0,32'hC0DE0007));

    #12;
    chk("rst done", 32'(mmio_done), 0);
    chk("rst sel", 32'(dev_sel), 0);
    chk("rst err_addr", err_addr, 0);
    chk("rst rdata", mmio_read_data, 0);
    @(negedge sys_clk);
    rst_n = 1;
    repeat (2) @(posedge sys_clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Conflicting read+write held for three cycles past the error.
    @(negedge sys_clk);
    mmio_read = 1; mmio_write = 1; mmio_addr = 32'hFFFF0000;
    @(posedge sys_clk); #1;
    chk("hold first_done", 32'(mmio_done), 1);
    chk("hold first_err", 32'(mmio_error), 1);
    last_err = 32'hFFFF0000;
    pulses = 0;
    repeat (3) begin
      @(posedge sys_clk); #1;
      if (mmio_done || dev_sel != 0 || dev_read || dev_write) pulses++;
    end
    chk("hold no_reissue", 32'(pulses), 0);
    @(negedge sys_clk);
    mmio_read = 0; mmio_write = 0;
    repeat (2) @(posedge sys_clk);

    // Reset in the middle of an access.
    @(negedge sys_clk);
    mmio_write = 1; mmio_addr = 32'hFFFF0020; lat_all = 8'd255;
    repeat (2) @(posedge sys_clk);
    #1 chk("rst_mid sel_before", 32'(dev_sel), 32'h1);
    @(negedge sys_clk);
    rst_n = 0;
    #1;
    chk("rst_mid sel", 32'(dev_sel), 0);
    chk("rst_mid write", 32'(dev_write), 0);
    chk("rst_mid addr", dev_addr, 0);
    chk("rst_mid err_addr", err_addr, 0);
    last_err = 0;
    @(negedge sys_clk);
    mmio_write = 0;
    rst_n = 1;
    pulses = 0;
    repeat (3) begin
      @(posedge sys_clk); #1;
      if (mmio_done) pulses++;
    end
    chk("rst_mid no_done", 32'(pulses), 0);
    run_vec(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mmio_xbar.md
Name: mmio_xbar

Overview:
- Parametrised, registered successor to the fixed-slot MMIO fan-out: routes one CPU MMIO request to one of N_DEVS device channels through a per-channel base/mask decode table.
- Adds a multi-cycle handshake, a timeout for unresponsive devices, and bus-error reporting for unmapped or illegal accesses.
- Sits between the CPU memory stage and the MMIO device modules (switches, LEDs, seg7, UART, buttons, ROM, and future ones).

Parameters:
- N_DEVS, 8, number of device channels.
- DEV_BASE, {N_DEVS{32'h0}}, flattened N_DEVS×32 base addresses; channel i uses bits [32i+31:32i].
- DEV_MASK, {N_DEVS{32'hFFFFFFFF}}, flattened N_DEVS×32 compare masks, same packing.
- TIMEOUT, 255, maximum cycles to wait for dev_done; range 1..65535.
- ERR_RDATA, 32'hDEADBEEF, read data returned on any error.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  reset.
- mmio_read  in  1  CPU read request; level, held until mmio_done.
- mmio_write  in  1  CPU write request; level, held until mmio_done.
- mmio_addr  in  32  CPU address.
- mmio_write_data  in  32  CPU write data.
- mmio_done  out  1  one-cycle completion pulse.
- mmio_read_data  out  32  read data, valid while mmio_done=1.
- mmio_error  out  1  error flag, valid while mmio_done=1.
- err_addr  out  32  address of the most recent errored access.
- dev_sel  out  N_DEVS  one-hot channel select.
- dev_read  out  1  broadcast read strobe.
- dev_write  out  1  broadcast write strobe.
- dev_addr  out  32  broadcast latched address.
- dev_wdata  out  32  broadcast latched write data.
- dev_done  in  N_DEVS  per-channel completion.
- dev_rdata  in  N_DEVS×32  per-channel read data, flattened.

Behaviour:
- Clock and reset: one clock, sys_clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; timeout counter 0. Asserting reset mid-transaction aborts it; no mmio_done is issued.
- Decode: hit[i] = ((mmio_addr & MASK[i]) == (BASE[i] & MASK[i])). The lowest index hit wins when several match.
- IDLE: on (mmio_read | mmio_write), latch addr, wdata and op into dev_addr, dev_wdata, dev_read/dev_write.
  - Exactly one of read/write and a hit: dev_sel <= onehot(winner); go ACCESS.
  - read and write both 1, or no hit: go RESP with error; no device is strobed.
- ACCESS: dev_sel, dev_read/dev_write and dev_addr/dev_wdata are held stable.
  - Counter increments each cycle.
  - If dev_done[sel]=1: capture dev_rdata[sel] (0 on writes); go RESP with no error.
  - Else if counter == TIMEOUT-1: go RESP with error.
  - dev_done on unselected channels is ignored.
- RESP: for exactly one cycle, mmio_done=1 and mmio_read_data is the captured data, or ERR_RDATA on error (on writes too). mmio_error is set accordingly.
  - Same cycle: dev_sel, dev_read, dev_write <= 0; counter <= 0.
  - On error, err_addr <= latched address.
  - Go RELEASE.
- RELEASE: wait until mmio_read=0 and mmio_write=0, then go IDLE. This guarantees no re-issue of a held request. mmio_done=0 in this state.
- Latency: request seen in IDLE at cycle 0 → dev_sel at cycle 1.
  - Device done at cycle k ≥ 1 → mmio_done at k+1. A zero-wait device gives mmio_done at cycle 2.
  - Error decode → mmio_done at cycle 1.
  - Timeout → mmio_done at cycle TIMEOUT+1.
- Outputs: all registered; no combinational path from the CPU inputs to any output.
- Stability: address and data changes while in ACCESS are ignored, because the latched values are used.

Test Plan:
- BASE[0]=FFFF0000/MASK FFFFFF80, BASE[1]=FFFF0080/MASK FFFFFF80. Read FFFF0084, dev1 done at cycle 1 with 0x12345678 → dev_sel=0b10 at cycle 1; mmio_done=1, rdata 0x12345678, error=0 at cycle 2.
- Read 0x00001000, which hits no channel → mmio_done at cycle 1, rdata DEADBEEF, error=1, err_addr=00001000, dev_sel stays 0.
- TIMEOUT=4, write to channel 0, dev_done never asserted → mmio_done+error at cycle 5; dev_sel drops the same cycle.
- mmio_read and mmio_write both 1 → immediate error response; then CPU holds the request 3 more cycles → no second transaction until release.
- Overlapping channels 2 and 5 both hit → only dev_sel[2]. dev_done[5] pulsed during ACCESS → ignored.
- rst_n low during ACCESS → all outputs 0 asynchronously. After release, a new read completes normally.
